// File: rtl/mips_multicycle_if.sv
// Instruction and data memory ports of the multi-cycle MIPS core.
// Each req is a level held until ready is seen on a rising edge.
interface mips_multicycle_if #(parameter int XLEN = 16);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [15:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mips_multicycle.sv
// Multi-cycle 16-bit-encoding MIPS core with an XLEN-wide datapath.
// A five-state FSM (FETCH/DECODE/EXEC/MEM/WB) sequences the wait-stated memories.
module mips_multicycle #(
  parameter int              XLEN     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  mips_multicycle_if.master mem,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   alu_result,
  output logic              retire
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;
  localparam logic [2:0] OP_R = 3'd0, OP_ADDI = 3'd1, OP_LW = 3'd2, OP_SW = 3'd3,
                         OP_BEQ = 3'd4, OP_J = 3'd5, OP_JAL = 3'd6, OP_ORI = 3'd7;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc2_q, a_q, b_q, mdr_q, alu_q, alu_d;
  logic [15:0]     ir_q;
  logic [XLEN-1:0] rf_q [8];
  logic            retire_q, retire_d;
  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [2:0]      op, rs, rt, rd;
  logic [3:0]      funct;
  logic [XLEN-1:0] simm, zimm, btgt, jtgt;
  logic            alu_wb;

  assign op     = ir_q[15:13];
  assign rs     = ir_q[12:10];
  assign rt     = ir_q[9:7];
  assign rd     = ir_q[6:4];
  assign funct  = ir_q[3:0];
  assign simm   = {{(XLEN-7){ir_q[6]}}, ir_q[6:0]};
  assign zimm   = {{(XLEN-7){1'b0}}, ir_q[6:0]};
  assign btgt   = pc2_q + (simm << 1);
  assign alu_wb = (op == OP_R && funct <= 4'd4) || op == OP_ADDI || op == OP_ORI;

  // Jumps keep the upper bits of pc2 and replace the low 14 with target*2.
  always_comb begin
    jtgt       = pc2_q;
    jtgt[13:0] = {ir_q[12:0], 1'b0};
  end

  always_comb begin
    alu_d = '0;
    case (op)
      OP_R: begin
        case (funct)
          4'd0:    alu_d = a_q + b_q;
          4'd1:    alu_d = a_q - b_q;
          4'd2:    alu_d = a_q & b_q;
          4'd3:    alu_d = a_q | b_q;
          4'd4:    alu_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
          4'd8:    alu_d = a_q;
          default: alu_d = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_d = a_q + simm;
      OP_ORI:                alu_d = a_q | zimm;
      OP_BEQ:                alu_d = btgt;
      default:               alu_d = jtgt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem.imem_ready) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC: begin
        if (op == OP_LW || op == OP_SW) state_d = MEM;
        else if (alu_wb)                state_d = WB;
        else                            state_d = FETCH;
      end
      MEM:     if (mem.dmem_ready) state_d = (op == OP_SW) ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Requests are gated by reset so an outstanding access drops immediately.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    pc_d         = pc_q;
    rf_we        = 1'b0;
    rf_waddr     = rt;
    rf_wdata     = alu_q;
    retire_d     = (state_q != FETCH) && (state_d == FETCH);
    case (state_q)
      FETCH: mem.imem_req = !reset;
      EXEC: begin
        if (state_d == FETCH) begin
          pc_d = pc2_q;
          if (op == OP_BEQ && a_q == b_q)       pc_d = btgt;
          else if (op == OP_J || op == OP_JAL)  pc_d = jtgt;
          else if (op == OP_R && funct == 4'd8) pc_d = a_q;
          if (op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 3'd7;
            rf_wdata = pc2_q;
          end
        end
      end
      MEM: begin
        mem.dmem_req = !reset;
        mem.dmem_we  = !reset && (op == OP_SW);
        if (mem.dmem_ready && op == OP_SW) pc_d = pc2_q;
      end
      WB: begin
        pc_d     = pc2_q;
        rf_we    = 1'b1;
        rf_waddr = (op == OP_R) ? rd : rt;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      pc2_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mdr_q    <= '0;
      alu_q    <= '0;
      retire_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      retire_q <= retire_d;
      if (state_q == FETCH && mem.imem_ready) begin
        ir_q  <= mem.imem_rdata;
        pc2_q <= pc_q + XLEN'(2);
      end
      if (state_q == DECODE) begin
        a_q <= rf_q[rs];
        b_q <= rf_q[rt];
      end
      if (state_q == EXEC) alu_q <= alu_d;
      if (state_q == MEM && mem.dmem_ready) mdr_q <= mem.dmem_rdata;
      // r0 is never written, so it keeps its reset value of zero.
      if (rf_we && rf_waddr != 3'd0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem.imem_addr  = pc_q;
  assign mem.dmem_addr  = alu_q;
  assign mem.dmem_wdata = b_q;
  assign pc_out         = pc_q;
  assign alu_result     = alu_q;
  assign retire         = retire_q;
endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: directed program steps plus random instructions,
// each checked against an instruction-level model of the architecture.
module tb_mips_multicycle;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  typedef logic [XLEN-1:0] word_t;

  logic  clk = 1'b0;
  logic  reset;
  word_t pc_out, alu_result;
  logic  retire;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_if #(.XLEN(XLEN)) bus ();

  mips_multicycle #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .mem(bus),
    .pc_out(pc_out), .alu_result(alu_result), .retire(retire)
  );

  // Architectural state of the reference model.
  word_t m_pc;
  word_t m_reg [8];
  word_t m_mem [word_t];

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
  endtask

  // Executes one instruction on the model; returns what the bus and outputs must show.
  task automatic model(input logic [15:0] ins, output word_t npc, output int lat,
                       output bit achk, output word_t ealu, output int mk,
                       output word_t maddr, output word_t mwd, output word_t ld);
    int    op, rs, rt, rd, fn, widx;
    word_t a, b, simm, zimm, pc2, wval;
    op = int'(ins[15:13]); rs = int'(ins[12:10]); rt = int'(ins[9:7]);
    rd = int'(ins[6:4]);   fn = int'(ins[3:0]);
    a = m_reg[rs]; b = m_reg[rt];
    zimm = word_t'(ins[6:0]);
    simm = ins[6] ? zimm - 32'd128 : zimm;
    pc2  = m_pc + 32'd2;
    npc = pc2; lat = 3; achk = 1'b0; ealu = '0; mk = 0; maddr = '0; mwd = '0; ld = '0;
    widx = -1; wval = '0;
    case (op)
      0: begin
        if (fn <= 4) begin
          case (fn)
            0: ealu = a + b;
            1: ealu = a - b;
            2: ealu = a & b;
            3: ealu = a | b;
            default: ealu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          endcase
          lat = 4; achk = 1'b1; widx = rd; wval = ealu;
        end else if (fn == 8) npc = a;
      end
      1: begin ealu = a + simm; lat = 4; achk = 1'b1; widx = rt; wval = ealu; end
      2: begin
        ealu = a + simm; maddr = ealu; lat = 5; achk = 1'b1; mk = 1;
        if (!m_mem.exists(maddr)) m_mem[maddr] = word_t'($urandom);
        ld = m_mem[maddr]; widx = rt; wval = ld;
      end
      3: begin
        ealu = a + simm; maddr = ealu; lat = 4; achk = 1'b1; mk = 2; mwd = b;
        m_mem[maddr] = b;
      end
      4: if (a == b) npc = pc2 + simm * 2;
      5: npc = (pc2 / 32'd16384) * 32'd16384 + word_t'(ins[12:0]) * 2;
      6: begin
        npc = (pc2 / 32'd16384) * 32'd16384 + word_t'(ins[12:0]) * 2;
        widx = 7; wval = pc2;
      end
      default: begin ealu = a | zimm; lat = 4; achk = 1'b1; widx = rt; wval = ealu; end
    endcase
    if (widx > 0) m_reg[widx] = wval;
    m_pc = npc;
  endtask

  // Entered just after a negedge with the core in FETCH; returns just after the
  // negedge in which retire is seen (the next FETCH cycle).
  task automatic run(input string tag, input logic [15:0] ins, input int iw,
                     input int dw, input bit abort);
    word_t pc0, npc, ealu, maddr, mwd, ld;
    int    lat, mk, cyc, icnt, dcnt, total;
    bit    achk, done;
    pc0 = m_pc;
    model(ins, npc, lat, achk, ealu, mk, maddr, mwd, ld);
    total = lat + iw + ((mk != 0) ? dw : 0);
    cyc = 0; icnt = 0; dcnt = 0; done = 1'b0;
    while (!done) begin
      if (cyc > 0 && retire) begin
        done = 1'b1;
      end else if (cyc > 60) begin
        chk({tag, "_timeout"}, word_t'(cyc), word_t'(total));
        done = 1'b1;
      end else begin
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.imem_rdata = 16'($urandom);
        bus.dmem_rdata = word_t'($urandom);
        if (bus.imem_req) begin
          chk({tag, "_imem_addr"}, bus.imem_addr, pc0);
          if (icnt == iw) begin bus.imem_ready = 1'b1; bus.imem_rdata = ins; end
          icnt++;
        end
        if (bus.dmem_req) begin
          if (abort) begin
            reset = 1'b1;
            #1;
            chk({tag, "_dmem_req_drop"}, word_t'(bus.dmem_req), '0);
            chk({tag, "_imem_req_rst"}, word_t'(bus.imem_req), '0);
            bus.dmem_ready = 1'b0;
            return;
          end
          chk({tag, "_dmem_we"}, word_t'(bus.dmem_we), word_t'(mk == 2));
          chk({tag, "_dmem_addr"}, bus.dmem_addr, maddr);
          if (mk == 2) chk({tag, "_dmem_wdata"}, bus.dmem_wdata, mwd);
          if (dcnt == dw) begin bus.dmem_ready = 1'b1; if (mk == 1) bus.dmem_rdata = ld; end
          dcnt++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    chk({tag, "_latency"}, word_t'(cyc), word_t'(total));
    chk({tag, "_pc_out"}, pc_out, npc);
    chk({tag, "_fetch_cycles"}, word_t'(icnt), word_t'(iw + 1));
    chk({tag, "_dmem_cycles"}, word_t'(dcnt), word_t'((mk != 0) ? dw + 1 : 0));
    if (achk) chk({tag, "_alu_result"}, alu_result, ealu);
  endtask

  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {3'd0, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {3'(op), 3'(rs), 3'(rt), 7'(imm)};
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_imem_req"}, word_t'(bus.imem_req), '0);
    chk({tag, "_dmem_req"}, word_t'(bus.dmem_req), '0);
    chk({tag, "_dmem_we"}, word_t'(bus.dmem_we), '0);
    chk({tag, "_retire"}, word_t'(retire), '0);
    chk({tag, "_pc_out"}, pc_out, RESET_PC);
    chk({tag, "_alu_result"}, alu_result, '0);
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    #1;
    chk("startup_imem_req", word_t'(bus.imem_req), 32'd1);

    // ADDI, fetch waits, ADD
    run("addi_r1", enc_i(1, 0, 1, 5), 0, 0, 0);
    run("addi_r2", enc_i(1, 0, 2, 7), 0, 0, 0);
    run("add_r3_wait", enc_r(1, 2, 3, 0), 3, 0, 0);
    // memory round trip with data wait states; the final SW exposes r4
    run("sw_r3", enc_i(3, 0, 3, 4), 0, 2, 0);
    run("lw_r4", enc_i(2, 0, 4, 4), 0, 2, 0);
    run("sw_r4", enc_i(3, 0, 4, 8), 1, 0, 0);
    // control flow
    run("j_to_8", {3'd5, 13'd4}, 0, 0, 0);
    run("beq_back", enc_i(4, 1, 1, -2), 0, 0, 0);
    run("j_0x80", {3'd5, 13'h40}, 0, 0, 0);
    run("jal", {3'd6, 13'h100}, 2, 0, 0);
    run("sw_r7", enc_i(3, 0, 7, 0), 0, 0, 0);
    run("jr_r7", enc_r(7, 0, 0, 8), 0, 0, 0);
    run("beq_not_taken", enc_i(4, 1, 2, 10), 0, 0, 0);
    // wide datapath and edge cases
    run("addi_m1", enc_i(1, 0, 1, -1), 0, 0, 0);
    run("slt", enc_r(1, 0, 2, 4), 0, 0, 0);
    run("sw_r2", enc_i(3, 0, 2, 12), 0, 0, 0);
    run("addi_r0", enc_i(1, 0, 0, 3), 0, 0, 0);
    run("sw_r0", enc_i(3, 0, 0, 16), 0, 1, 0);
    run("nop_f", enc_r(1, 2, 3, 15), 0, 0, 0);
    run("sw_r3_after_nop", enc_i(3, 0, 3, 20), 0, 0, 0);
    run("ori", enc_i(7, 1, 5, 7'h55), 0, 0, 0);
    run("sub", enc_r(5, 1, 6, 1), 0, 0, 0);

    // random instructions with random wait states
    for (int n = 0; n < 200; n++)
      run("rand", 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);

    // reset during a data wait; fetch must restart at RESET_PC with a clean register file
    run("abort_sw", enc_i(3, 1, 2, 0), 0, 3, 1);
    @(negedge clk);
    check_reset_state("abort_reset");
    model_reset();
    reset = 1'b0;
    #1;
    for (int r = 1; r < 8; r++) run("post_reset_sw", enc_i(3, 0, r, r * 2), 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
